subroutine_ctrl: RTL

Call/return sequencer that drives the processor's return-address stack. It sits between instruction decode and the stack. On a decoded call it pushes the return address and redirects the PC to the call target. On a decoded return it pops the stack, stalls fetch until the popped address is available, then redirects the PC to it. It also tracks stack occupancy and detects overflow and underflow.

---
 rtl/ras_pkg.sv | 13 +
 rtl/subroutine_ctrl_if.sv | 33 +++
 rtl/sat_updown_counter.sv | 24 ++
 rtl/subroutine_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared types and defaults for the call/return sequencer.
package ras_pkg;

  typedef enum logic [1:0] {IDLE, POP, WAIT} ras_state_t;

  localparam int ADDR_W_DEF = 12;
  localparam int DEPTH_DEF  = 4;

  function automatic int depth_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/subroutine_ctrl_if.sv
// Decode/stack/fetch signal bundle for subroutine_ctrl; slave is the sequencer side.
interface subroutine_ctrl_if
  import ras_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) ();

  logic                        is_call;
  logic                        is_ret;
  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           call_target;
  logic [ADDR_W-1:0]           ras_rdata;
  logic                        ras_push;
  logic                        ras_pop;
  logic [ADDR_W-1:0]           ras_wdata;
  logic                        stall;
  logic                        pc_redirect;
  logic [ADDR_W-1:0]           pc_next;
  logic [depth_w(DEPTH)-1:0]   depth;
  logic                        err;

  modport slave (
    input  is_call, is_ret, pc, call_target, ras_rdata,
    output ras_push, ras_pop, ras_wdata, stall, pc_redirect, pc_next, depth, err
  );

  modport master (
    output is_call, is_ret, pc, call_target, ras_rdata,
    input  ras_push, ras_pop, ras_wdata, stall, pc_redirect, pc_next, depth, err
  );

endinterface

// File: rtl/sat_updown_counter.sv
// Saturating up/down occupancy counter; simultaneous inc and dec cancel.
module sat_updown_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  assign full  = (count == W'(MAX));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= '0;
    else if (inc && !dec && !full) count <= count + W'(1);
    else if (dec && !inc && !empty) count <= count - W'(1);
  end

endmodule

// File: rtl/subroutine_ctrl.sv
// Call/return sequencer driving the return-address stack.
// RAS_ERR_TRAP_EN: trap overflow/underflow (suppress the op, set sticky err).
module subroutine_ctrl
  import ras_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  subroutine_ctrl_if.slave bus
);

  localparam int DW = depth_w(DEPTH);
`ifdef RAS_ERR_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  ras_state_t        state, state_n;
  logic              push_n, pop_n, stall_n, redir_n, err_n;
  logic              inc, dec, full, empty;
  logic [ADDR_W-1:0] wdata_n, pcnext_n;
  logic [DW-1:0]     count;

  sat_updown_counter #(.MAX(DEPTH), .W(DW)) u_depth (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (dec),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.depth = count;

  always_comb begin
    state_n  = state;
    push_n   = 1'b0;
    pop_n    = 1'b0;
    stall_n  = 1'b0;
    redir_n  = 1'b0;
    err_n    = bus.err;
    wdata_n  = bus.ras_wdata;
    pcnext_n = bus.pc_next;
    inc      = 1'b0;
    dec      = 1'b0;
    unique case (state)
      IDLE: begin
        // Call wins over a simultaneous return.
        if (bus.is_call) begin
          redir_n  = 1'b1;
          pcnext_n = bus.call_target;
          if (TRAP_EN && full) begin
            err_n = 1'b1;
          end else begin
            push_n  = 1'b1;
            wdata_n = bus.pc + ADDR_W'(1);
            inc     = 1'b1;
          end
        end else if (bus.is_ret) begin
          if (TRAP_EN && empty) begin
            err_n = 1'b1;
          end else begin
            state_n = POP;
            pop_n   = 1'b1;
            stall_n = 1'b1;
            dec     = 1'b1;
          end
        end
      end
      POP: begin
        state_n = WAIT;
        stall_n = 1'b1;
      end
      WAIT: begin
        // Stack data is valid only in this cycle, one after the pop strobe.
        state_n  = IDLE;
        redir_n  = 1'b1;
        pcnext_n = bus.ras_rdata;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.ras_push    <= 1'b0;
      bus.ras_pop     <= 1'b0;
      bus.ras_wdata   <= '0;
      bus.stall       <= 1'b0;
      bus.pc_redirect <= 1'b0;
      bus.pc_next     <= '0;
      bus.err         <= 1'b0;
    end else begin
      state           <= state_n;
      bus.ras_push    <= push_n;
      bus.ras_pop     <= pop_n;
      bus.ras_wdata   <= wdata_n;
      bus.stall       <= stall_n;
      bus.pc_redirect <= redir_n;
      bus.pc_next     <= pcnext_n;
      bus.err         <= err_n;
    end
  end

endmodule
